// File: rtl/send_cam.sv
// send_cam: camera-style byte-stream transmitter producing vsync/href framing from fetched 16-bit pixels
// Ports:
//   cmos_pclk  - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   cfg_done   - transmit enable (asynchronous, synchronized internally)
//   pix_data   - pixel to send, [15:8] goes out first
//   pix_req    - pixel-fetch strobe; pix_data is taken on the edge ending a pix_req-high cycle
//   cmos_data  - byte bus, 8'h00 whenever cmos_href is low
//   cmos_href  - high while a valid byte is on cmos_data
//   cmos_vsync - active-high frame sync
//   frame_done - one-cycle pulse in the last cycle of each frame
module send_cam #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int HBLANK_CYC = 144,
   parameter int VSYNC_CYC  = 1568,
   parameter int VBACK_CYC  = 784,
   parameter int VFRONT_CYC = 784
) (
   input  logic        cmos_pclk,
   input  logic        rst,
   input  logic        cfg_done,
   input  logic [15:0] pix_data,
   output logic        pix_req,
   output logic [7:0]  cmos_data,
   output logic        cmos_href,
   output logic        cmos_vsync,
   output logic        frame_done
);
   localparam int LINE_CYC = 2 * H_ACTIVE;
   localparam int M1 = VSYNC_CYC > VBACK_CYC ? VSYNC_CYC : VBACK_CYC;
   localparam int M2 = M1 > VFRONT_CYC ? M1 : VFRONT_CYC;
   localparam int M3 = M2 > HBLANK_CYC ? M2 : HBLANK_CYC;
   localparam int CMAX = M3 > LINE_CYC ? M3 : LINE_CYC;
   localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
   localparam int LW = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
   localparam logic [CW-1:0] VS_END = CW'(VSYNC_CYC - 1);
   localparam logic [CW-1:0] VB_END = CW'(VBACK_CYC - 1);
   localparam logic [CW-1:0] LN_END = CW'(LINE_CYC - 1);
   localparam logic [CW-1:0] HB_END = CW'(HBLANK_CYC - 1);
   localparam logic [CW-1:0] VF_END = CW'(VFRONT_CYC - 1);
   localparam logic [LW-1:0] LAST_LINE = LW'(V_ACTIVE - 1);

   typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT} state_t;

   state_t         st, ns;
   logic [CW-1:0]  cnt, nc;
   logic [LW-1:0]  line, nl;
   logic           sync1, en_s;
   logic [7:0]     hold_lo;
   logic           href_d, vsync_d, done_d;
   logic [7:0]     data_d;

   always_ff @(posedge cmos_pclk or posedge rst) begin
      if (rst) begin
         sync1      <= 1'b0;
         en_s       <= 1'b0;
         st         <= IDLE;
         cnt        <= '0;
         line       <= '0;
         hold_lo    <= 8'h00;
         cmos_data  <= 8'h00;
         cmos_href  <= 1'b0;
         cmos_vsync <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         sync1      <= cfg_done;
         en_s       <= sync1;
         st         <= ns;
         cnt        <= nc;
         line       <= nl;
         cmos_data  <= data_d;
         cmos_href  <= href_d;
         cmos_vsync <= vsync_d;
         frame_done <= done_d;
         if (pix_req) hold_lo <= pix_data[7:0];
      end
   end

   // Each state counts 0..len-1; the counter restarts at every transition.
   // en_s is consulted only in IDLE and at the end of VFRONT, so a frame
   // once started always runs to completion.
   always_comb begin
      ns = st;
      nc = cnt + CW'(1);
      nl = line;
      case (st)
         IDLE: begin
            nc = '0;
            nl = '0;
            ns = en_s ? VSYNC : IDLE;
         end
         VSYNC: begin
            nl = '0;
            if (cnt == VS_END) begin
               ns = VBACK;
               nc = '0;
            end
         end
         VBACK: if (cnt == VB_END) begin
            ns = ACTIVE;
            nc = '0;
         end
         ACTIVE: if (cnt == LN_END) begin
            nc = '0;
            ns = line == LAST_LINE ? VFRONT : HBLANK;
            nl = line == LAST_LINE ? line : line + LW'(1);
         end
         HBLANK: if (cnt == HB_END) begin
            ns = ACTIVE;
            nc = '0;
         end
         VFRONT: if (cnt == VF_END) begin
            ns = en_s ? VSYNC : IDLE;
            nc = '0;
         end
         default: begin
            ns = IDLE;
            nc = '0;
         end
      endcase
   end

   // Outputs are registered from the next state, so they line up with the
   // state they describe. pix_req looks one cycle ahead: it is high when the
   // coming cycle is an even (high-byte) ACTIVE cycle.
   always_comb begin
      href_d  = ns == ACTIVE;
      pix_req = href_d && !nc[0];
      data_d  = !href_d ? 8'h00 : nc[0] ? hold_lo : pix_data[15:8];
      vsync_d = ns == VSYNC;
      done_d  = ns == VFRONT && nc == VF_END;
   end
endmodule

// File: tb/tb_send_cam.sv
// tb_send_cam: self-checking bench for send_cam against a frame-timing model and pixel scoreboard
module tb_send_cam;
   localparam int H = 4, V = 2, HB = 3, VS = 2, VB = 2, VF = 2;
   localparam int ACT = V * 2 * H + (V - 1) * HB;
   localparam int FR = VS + VB + ACT + VF;

   logic        clk = 1'b0, rst = 1'b0, cfg_done = 1'b0;
   logic [15:0] pix_data = 16'h0000;
   logic        pix_req, cmos_href, cmos_vsync, frame_done;
   logic [7:0]  cmos_data;

   int compared = 0, mismatched = 0;
   int inc_n = 0;
   bit inc_mode = 1'b1;
   bit rx_phase = 1'b0;
   logic [15:0] rx_word;
   logic [15:0] q[$];
   logic [15:0] tx_log[$];
   logic [15:0] rx_log[$];

   send_cam #(.H_ACTIVE(H), .V_ACTIVE(V), .HBLANK_CYC(HB), .VSYNC_CYC(VS),
              .VBACK_CYC(VB), .VFRONT_CYC(VF)) dut (
      .cmos_pclk(clk), .rst(rst), .cfg_done(cfg_done), .pix_data(pix_data),
      .pix_req(pix_req), .cmos_data(cmos_data), .cmos_href(cmos_href),
      .cmos_vsync(cmos_vsync), .frame_done(frame_done));

   always #5 clk = ~clk;

   // Expected framing for cycle k of a frame (k=0 is the first vsync cycle).
   function automatic void ref_at(input int k, output logic vs, output logic hr,
                                  output logic fd, output logic hi);
      int t, p;
      vs = 1'b0; hr = 1'b0; fd = 1'b0; hi = 1'b0;
      t = k;
      if (t < VS) begin
         vs = 1'b1;
         return;
      end
      t -= VS;
      if (t < VB) return;
      t -= VB;
      if (t < ACT) begin
         p = t % (2 * H + HB);
         hr = p < 2 * H;
         hi = hr && (p % 2 == 0);
         return;
      end
      t -= ACT;
      fd = t == VF - 1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive();
      logic [15:0] v;
      if (pix_req) begin
         v = inc_mode ? 16'h0100 + 16'(inc_n) * 16'h0202 : 16'($urandom);
         inc_n++;
         q.push_back(v);
         tx_log.push_back(v);
         pix_data = v;
      end else pix_data = 16'($urandom);
   endtask

   task automatic wait_vsync(output int edges);
      q.delete();
      edges = 0;
      while (!cmos_vsync && edges < 100) begin
         step();
         edges++;
         compared++;
         if (cmos_href !== 1'b0) begin
            mismatched++;
            $display("FAIL pre_vsync_href edge=%0d got %b expected 0", edges, cmos_href);
         end
         if (!cmos_vsync) drive();
      end
      compared++;
      if (cmos_vsync !== 1'b1) begin
         mismatched++;
         $display("FAIL vsync_timeout got %b expected 1 within 100 edges", cmos_vsync);
      end
   endtask

   task automatic run_frames(input int nf, input int drop_at, input int stop_at,
                             input bit sampled, output int href_cnt);
      logic vs, hr, fd, hi, vs1, hr1, fd1, hi1;
      logic [7:0] eb;
      logic [15:0] w;
      int abs_c, last_done;
      href_cnt = 0;
      last_done = -1;
      abs_c = 0;
      for (int f = 0; f < nf; f++) begin
         for (int k = 0; k < FR; k++) begin
            if (!(sampled && f == 0 && k == 0)) step();
            if (f == 0 && k == drop_at) cfg_done = 1'b0;
            ref_at(k, vs, hr, fd, hi);
            ref_at((k + 1) % FR, vs1, hr1, fd1, hi1);
            compared++;
            if ({cmos_vsync, cmos_href, frame_done} !== {vs, hr, fd}) begin
               mismatched++;
               $display("FAIL ctrl f=%0d k=%0d got vs/href/done=%b%b%b expected %b%b%b",
                        f, k, cmos_vsync, cmos_href, frame_done, vs, hr, fd);
            end
            eb = 8'h00;
            if (hr) begin
               compared++;
               if (q.size() == 0) begin
                  mismatched++;
                  $display("FAIL pixel_missing f=%0d k=%0d got no fetched pixel expected one", f, k);
               end else begin
                  w = q[0];
                  eb = hi ? w[15:8] : w[7:0];
                  if (!hi) void'(q.pop_front());
               end
            end
            compared++;
            if (cmos_data !== eb) begin
               mismatched++;
               $display("FAIL data f=%0d k=%0d got %h expected %h", f, k, cmos_data, eb);
            end
            compared++;
            if (pix_req !== (hr1 && hi1)) begin
               mismatched++;
               $display("FAIL pix_req f=%0d k=%0d got %b expected %b", f, k, pix_req, hr1 && hi1);
            end
            if (cmos_href) begin
               href_cnt++;
               if (!rx_phase) rx_word[15:8] = cmos_data;
               else begin
                  rx_word[7:0] = cmos_data;
                  rx_log.push_back(rx_word);
               end
               rx_phase = ~rx_phase;
            end else rx_phase = 1'b0;
            if (frame_done) begin
               if (last_done >= 0) begin
                  compared++;
                  if (abs_c - last_done != FR) begin
                     mismatched++;
                     $display("FAIL done_period got %0d expected %0d", abs_c - last_done, FR);
                  end
               end
               last_done = abs_c;
            end
            abs_c++;
            if (f == 0 && k == stop_at) return;
            drive();
         end
      end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      cfg_done = 1'b0;
      repeat (3) step();
      compared++;
      if ({pix_req, cmos_data, cmos_href, cmos_vsync, frame_done} !== 12'h000) begin
         mismatched++;
         $display("FAIL reset_outputs got %h expected 000",
                  {pix_req, cmos_data, cmos_href, cmos_vsync, frame_done});
      end
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         compared++;
         if ({cmos_vsync, cmos_href, pix_req} !== 3'b000) begin
            mismatched++;
            $display("FAIL idle_disabled cyc=%0d got %b expected 000", i,
                     {cmos_vsync, cmos_href, pix_req});
         end
         drive();
      end
   endtask

   task automatic test_startup_incrementing();
      int e, hc;
      inc_mode = 1'b1;
      inc_n = 0;
      @(negedge clk) rst = 1'b1;
      cfg_done = 1'b1;
      @(negedge clk) rst = 1'b0;
      wait_vsync(e);
      compared++;
      if (e != 3) begin
         mismatched++;
         $display("FAIL startup_edges got %0d expected 3", e);
      end
      run_frames(2, -1, -1, 1'b1, hc);
      compared++;
      if (hc != 2 * V * 2 * H) begin
         mismatched++;
         $display("FAIL startup_href_count got %0d expected %0d", hc, 2 * V * 2 * H);
      end
      compared++;
      if (inc_n != 2 * V * H) begin
         mismatched++;
         $display("FAIL startup_pix_req_count got %0d expected %0d", inc_n, 2 * V * H);
      end
   endtask

   task automatic test_back_to_back_random();
      int hc;
      inc_mode = 1'b0;
      run_frames(2, -1, -1, 1'b0, hc);
      compared++;
      if (hc != 2 * V * 2 * H) begin
         mismatched++;
         $display("FAIL b2b_href_count got %0d expected %0d", hc, 2 * V * 2 * H);
      end
   endtask

   task automatic test_loopback();
      int hc;
      tx_log.delete();
      rx_log.delete();
      run_frames(1, -1, -1, 1'b0, hc);
      compared++;
      if (rx_log.size() != tx_log.size() || rx_log.size() != V * H) begin
         mismatched++;
         $display("FAIL loop_count got rx=%0d tx=%0d expected %0d", rx_log.size(),
                  tx_log.size(), V * H);
      end else begin
         for (int i = 0; i < rx_log.size(); i++) begin
            compared++;
            if (rx_log[i] !== tx_log[i]) begin
               mismatched++;
               $display("FAIL loop_word i=%0d got %h expected %h", i, rx_log[i], tx_log[i]);
            end
         end
      end
   endtask

   task automatic test_cfg_drop();
      int hc;
      run_frames(1, VS + VB + 2, -1, 1'b0, hc);
      compared++;
      if (hc != V * 2 * H) begin
         mismatched++;
         $display("FAIL drop_href_count got %0d expected %0d", hc, V * 2 * H);
      end
      for (int i = 0; i < 30; i++) begin
         step();
         compared++;
         if ({cmos_vsync, cmos_href, frame_done, pix_req} !== 4'b0000) begin
            mismatched++;
            $display("FAIL drop_idle cyc=%0d got %b expected 0000", i,
                     {cmos_vsync, cmos_href, frame_done, pix_req});
         end
         drive();
      end
   endtask

   task automatic test_rst_mid_line();
      int e, hc;
      cfg_done = 1'b1;
      wait_vsync(e);
      compared++;
      if (e != 3) begin
         mismatched++;
         $display("FAIL rearm_edges got %0d expected 3", e);
      end
      run_frames(1, -1, VS + VB + 3, 1'b1, hc);
      #3 rst = 1'b1;
      #1;
      compared++;
      if ({cmos_href, cmos_data, cmos_vsync, pix_req, frame_done} !== 12'h000) begin
         mismatched++;
         $display("FAIL async_reset got %h expected 000",
                  {cmos_href, cmos_data, cmos_vsync, pix_req, frame_done});
      end
      repeat (2) step();
      @(negedge clk) rst = 1'b0;
      wait_vsync(e);
      compared++;
      if (e != 3) begin
         mismatched++;
         $display("FAIL post_reset_edges got %0d expected 3", e);
      end
      run_frames(1, -1, -1, 1'b1, hc);
      compared++;
      if (hc != V * 2 * H) begin
         mismatched++;
         $display("FAIL post_reset_href_count got %0d expected %0d", hc, V * 2 * H);
      end
   endtask

   initial begin
      test_reset();
      test_startup_incrementing();
      test_back_to_back_random();
      test_loopback();
      test_cfg_drop();
      test_rst_mid_line();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/send_cam.md
SEND_CAM -- requirements
Module: send_cam

Interface
REQ-001 Parameter H_ACTIVE, 640, pixels per line (each pixel = 2 bytes).
REQ-002 Parameter V_ACTIVE, 480, active lines per frame.
REQ-003 Parameter HBLANK_CYC, 144, href-low cycles between consecutive active lines.
REQ-004 Parameter VSYNC_CYC, 1568, cycles cmos_vsync is high.
REQ-005 Parameter VBACK_CYC, 784, cycles from vsync fall to first href.
REQ-006 Parameter VFRONT_CYC, 784, cycles from last href fall to frame end.
REQ-007 cmos_pclk  input  1  sole clock; all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 cfg_done  input  1  transmit enable, asynchronous to cmos_pclk.
REQ-010 pix_data  input  16  pixel to send; [15:8] transmitted first.
REQ-011 pix_req  output  1  pixel-fetch strobe; pix_data is sampled on the edge closing a pix_req-high cycle.
REQ-012 cmos_data  output  8  byte bus toward the sensor-side receiver.
REQ-013 cmos_href  output  1  high while a valid byte is on cmos_data.
REQ-014 cmos_vsync  output  1  active-high frame sync.
REQ-015 frame_done  output  1  one-cycle pulse at end of each frame.

Function
REQ-016 cfg_done SHALL pass a 2-flop synchronizer; the FSM uses only the synchronized value (en_s).
REQ-017 FSM states SHALL be IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT.
REQ-018 IDLE: all outputs 0; move to VSYNC on the edge where en_s=1.
REQ-019 VSYNC: cmos_vsync=1 for exactly VSYNC_CYC cycles, then VBACK.
REQ-020 VBACK: all outputs 0 for VBACK_CYC cycles, then ACTIVE (line 0).
REQ-021 ACTIVE: cmos_href=1 for exactly 2*H_ACTIVE consecutive cycles; even byte cycles carry pix_data[15:8], odd cycles the [7:0] of the same sampled pixel.
REQ-022 pix_req SHALL be high exactly in the cycle preceding each high-byte cycle, i.e. H_ACTIVE pulses per line, never during href-low periods except the cycle before a line's first byte.
REQ-023 The sampled pixel SHALL be held internally; pix_data may change after the sampling edge without affecting the low byte.
REQ-024 After a line that is not the last: HBLANK for HBLANK_CYC cycles, then ACTIVE for next line; after line V_ACTIVE-1: VFRONT.
REQ-025 VFRONT: all outputs 0 for VFRONT_CYC cycles; frame_done=1 in its final cycle; then VSYNC if en_s=1, else IDLE.
REQ-026 en_s falling mid-frame SHALL NOT truncate the frame; the current frame completes and the FSM then enters IDLE.
REQ-027 Whenever cmos_href=0, cmos_data SHALL be 8'h00.
REQ-028 cmos_data, cmos_href, cmos_vsync, frame_done SHALL be registered outputs.
REQ-029 Frame length SHALL be VSYNC_CYC+VBACK_CYC+V_ACTIVE*2*H_ACTIVE+(V_ACTIVE-1)*HBLANK_CYC+VFRONT_CYC cycles, with no gap between back-to-back frames.
REQ-030 Counters SHALL be sized by $clog2 of their maximum and SHALL wrap to 0 on each state transition; no counter overflow for any legal parameter set (all parameters >=1).

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, all counters 0, synchronizer flops 0, and all outputs 0, regardless of position in frame.
REQ-032 After rst release, a new frame SHALL start only from VSYNC, never mid-frame.

Verification (H_ACTIVE=4, V_ACTIVE=2, HBLANK_CYC=3, VSYNC_CYC=2, VBACK_CYC=2, VFRONT_CYC=2)
REQ-033 rst released, cfg_done=1 from then on -> cmos_vsync high after the 3rd rising edge, high 2 cycles; frame_done every 25 cycles.
REQ-034 pix_data = incrementing 16'h0100,16'h0302,... per pix_req -> cmos_data per line 01,00,03,02,05,04,07,06 with href high 8 cycles, 4 pix_req pulses per line, 8 per frame.
REQ-035 Check gap between lines: href low exactly 3 cycles with cmos_data=00; after line 1 no HBLANK, VFRONT 2 cycles.
REQ-036 cfg_done dropped during line 0 -> frame completes (16 href cycles total), frame_done pulses, FSM idles, vsync stays low.
REQ-037 rst asserted mid-line -> cmos_href, cmos_data, cmos_vsync, pix_req go 0 without a clock edge; after release with cfg_done=1, next activity is a full 2-cycle vsync.
REQ-038 Receiver loopback (packing href bytes high-first into 16 bits) -> recovered words equal transmitted pix_data sequence exactly.
